// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 timing constants and the control bundle carried down the video pipeline.
// Latency: none (package only).
// Backpressure: none; video timing is free-running.
package video_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  // Controls that must stay cycle-aligned with the pixel data.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic frame_start;
  } video_ctrl_t;

  // Map "inside the sync window" onto the pin level for the chosen polarity.
  function automatic logic sync_level(input logic in_window, input int active_high);
    return (active_high != 0) ? in_window : ~in_window;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster counters producing de, h/v sync and line/frame strobes.
// Latency: outputs are combinational decodes of the current counter state.
// Backpressure: none; counters advance every clock.
module video_timing_gen #(
  parameter int H_ACTIVE         = video_timing_pkg::H_ACTIVE,
  parameter int H_FP             = video_timing_pkg::H_FP,
  parameter int H_SYNC           = video_timing_pkg::H_SYNC,
  parameter int H_BP             = video_timing_pkg::H_BP,
  parameter int V_ACTIVE         = video_timing_pkg::V_ACTIVE,
  parameter int V_FP             = video_timing_pkg::V_FP,
  parameter int V_SYNC           = video_timing_pkg::V_SYNC,
  parameter int V_BP             = video_timing_pkg::V_BP,
  parameter int SYNC_ACTIVE_HIGH = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_de,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_frame_start,
  output logic o_line_end,
  output logic o_frame_end
);
  import video_timing_pkg::*;

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;

  logic w_h_last;
  logic w_v_last;
  logic w_h_act;
  logic w_v_act;
  logic w_h_sync_win;
  logic w_v_sync_win;

  assign w_h_last     = (int'(r_h_cnt) == HT - 1);
  assign w_v_last     = (int'(r_v_cnt) == VT - 1);
  assign w_h_act      = (int'(r_h_cnt) < H_ACTIVE);
  assign w_v_act      = (int'(r_v_cnt) < V_ACTIVE);
  assign w_h_sync_win = (int'(r_h_cnt) >= H_ACTIVE + H_FP) &&
                        (int'(r_h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
  assign w_v_sync_win = (int'(r_v_cnt) >= V_ACTIVE + V_FP) &&
                        (int'(r_v_cnt) <  V_ACTIVE + V_FP + V_SYNC);

  // Raster scan: h wraps every line, v advances on each h wrap and wraps per frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  assign o_de          = w_h_act && w_v_act;
  assign o_hsync       = sync_level(w_h_sync_win, SYNC_ACTIVE_HIGH);
  assign o_vsync       = sync_level(w_v_sync_win, SYNC_ACTIVE_HIGH);
  assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  // Last active pixel of an active line.
  assign o_line_end    = (int'(r_h_cnt) == H_ACTIVE - 1) && w_v_act;
  // Last clock of the last line; every scan counter wraps here.
  assign o_frame_end   = w_h_last && w_v_last;

endmodule

// File: rtl/fbuf_scanout.sv
// Scans the low-res framebuffer, replicating each pixel SCALING_FACTOR times in x and y, onto 640x480 video.
// Latency: 2 clks from raster counters to all outputs (address register, then framebuffer read).
// Backpressure: none; the display sink must accept one pixel every clock.
module fbuf_scanout #(
  parameter int FRAME_WIDTH      = 160,
  parameter int FRAME_HEIGHT     = 120,
  parameter int SCALING_FACTOR   = 4,
  parameter int FBUF_ADDR_WIDTH  = 16,
  parameter int FBUF_DATA_WIDTH  = 8,
  parameter int H_ACTIVE         = video_timing_pkg::H_ACTIVE,
  parameter int H_FP             = video_timing_pkg::H_FP,
  parameter int H_SYNC           = video_timing_pkg::H_SYNC,
  parameter int H_BP             = video_timing_pkg::H_BP,
  parameter int V_ACTIVE         = video_timing_pkg::V_ACTIVE,
  parameter int V_FP             = video_timing_pkg::V_FP,
  parameter int V_SYNC           = video_timing_pkg::V_SYNC,
  parameter int V_BP             = video_timing_pkg::V_BP,
  parameter int SYNC_ACTIVE_HIGH = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_rd_addr,
  output logic                       fbuf_rd_en,
  input  logic [FBUF_DATA_WIDTH-1:0] fbuf_rd_data,
  output logic [FBUF_DATA_WIDTH-1:0] pixel_color,
  output logic                       video_de,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       frame_start
);
  import video_timing_pkg::*;

  localparam int AW = FBUF_ADDR_WIDTH;
  localparam int SW = (SCALING_FACTOR > 1) ? $clog2(SCALING_FACTOR) : 1;
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam video_ctrl_t CTRL_RST = '{de: 1'b0, hsync: SYNC_IDLE, vsync: SYNC_IDLE, frame_start: 1'b0};

  // Geometry must tile the active area exactly and the frame must fit in the buffer.
  if (SCALING_FACTOR < 1) begin : g_bad_sf
    $fatal(1, "fbuf_scanout: SCALING_FACTOR must be >= 1");
  end
  if (FRAME_WIDTH * SCALING_FACTOR != H_ACTIVE) begin : g_bad_w
    $fatal(1, "fbuf_scanout: FRAME_WIDTH*SCALING_FACTOR != H_ACTIVE");
  end
  if (FRAME_HEIGHT * SCALING_FACTOR != V_ACTIVE) begin : g_bad_h
    $fatal(1, "fbuf_scanout: FRAME_HEIGHT*SCALING_FACTOR != V_ACTIVE");
  end
  if (longint'(FRAME_WIDTH) * longint'(FRAME_HEIGHT) > (longint'(1) << FBUF_ADDR_WIDTH)) begin : g_bad_a
    $fatal(1, "fbuf_scanout: frame does not fit in FBUF_ADDR_WIDTH");
  end

  logic w_de;
  logic w_hsync;
  logic w_vsync;
  logic w_frame_start;
  logic w_line_end;
  logic w_frame_end;

  video_timing_gen #(
    .H_ACTIVE         (H_ACTIVE),
    .H_FP             (H_FP),
    .H_SYNC           (H_SYNC),
    .H_BP             (H_BP),
    .V_ACTIVE         (V_ACTIVE),
    .V_FP             (V_FP),
    .V_SYNC           (V_SYNC),
    .V_BP             (V_BP),
    .SYNC_ACTIVE_HIGH (SYNC_ACTIVE_HIGH)
  ) u_timing (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_de          (w_de),
    .o_hsync       (w_hsync),
    .o_vsync       (w_vsync),
    .o_frame_start (w_frame_start),
    .o_line_end    (w_line_end),
    .o_frame_end   (w_frame_end)
  );

  // Source-pixel position, tracked incrementally so no multiplier is needed.
  logic [SW-1:0] r_x_sub;
  logic [SW-1:0] r_y_sub;
  logic [AW-1:0] r_col;
  logic [AW-1:0] r_row_base;

  logic          w_x_wrap;
  logic          w_y_wrap;
  logic [AW-1:0] w_addr;

  assign w_x_wrap = (int'(r_x_sub) == SCALING_FACTOR - 1);
  assign w_y_wrap = (int'(r_y_sub) == SCALING_FACTOR - 1);
  assign w_addr   = r_row_base + r_col;

  // Walk the stored frame: column every SF clocks, row every SF active lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_sub    <= '0;
      r_y_sub    <= '0;
      r_col      <= '0;
      r_row_base <= '0;
    end else if (w_frame_end) begin
      r_x_sub    <= '0;
      r_y_sub    <= '0;
      r_col      <= '0;
      r_row_base <= '0;
    end else if (w_line_end) begin
      // Line end wins over the in-line advance so col never runs past the row.
      r_x_sub <= '0;
      r_col   <= '0;
      if (w_y_wrap) begin
        r_y_sub    <= '0;
        r_row_base <= r_row_base + AW'(FRAME_WIDTH);
      end else begin
        r_y_sub <= r_y_sub + SW'(1);
      end
    end else if (w_de) begin
      if (w_x_wrap) begin
        r_x_sub <= '0;
        r_col   <= r_col + AW'(1);
      end else begin
        r_x_sub <= r_x_sub + SW'(1);
      end
    end
  end

  video_ctrl_t w_ctrl;
  video_ctrl_t r_ctrl_d1;
  video_ctrl_t r_ctrl_d2;
  logic [AW-1:0] r_rd_addr;
  logic          r_rd_en;

  assign w_ctrl = '{de: w_de, hsync: w_hsync, vsync: w_vsync, frame_start: w_frame_start};

  // Stage 1: present the read address; it holds through blanking so the bus stays quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr <= '0;
      r_rd_en   <= 1'b0;
      r_ctrl_d1 <= CTRL_RST;
    end else begin
      r_rd_en   <= w_de;
      r_ctrl_d1 <= w_ctrl;
      if (w_de) begin
        r_rd_addr <= w_addr;
      end
    end
  end

  // Stage 2: controls wait one more clock for the framebuffer to return data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl_d2 <= CTRL_RST;
    end else begin
      r_ctrl_d2 <= r_ctrl_d1;
    end
  end

  assign fbuf_rd_addr = r_rd_addr;
  assign fbuf_rd_en   = r_rd_en;
  // Read data lands the clock after rd_en, exactly when the controls reach stage 2;
  // gating with the registered de also forces black in blanking and straight out of reset.
  assign pixel_color  = r_ctrl_d2.de ? fbuf_rd_data : '0;
  assign video_de     = r_ctrl_d2.de;
  assign hsync        = r_ctrl_d2.hsync;
  assign vsync        = r_ctrl_d2.vsync;
  assign frame_start  = r_ctrl_d2.frame_start;

endmodule

// File: tb/tb_fbuf_scanout.sv
// Directed bench on a 4x3 frame, SF=2, 12x9 raster: colors, sync, frame_start, mid-frame reset, blanking.
// Expected values come from hand tables and raster arithmetic on the output sample index.
// The framebuffer model returns addr[7:0] one clock after rd_en, 8'hA5 otherwise (or 8'hFF in blanking mode).
module tb_fbuf_scanout;

  localparam int FW = 4;
  localparam int FH = 3;
  localparam int SF = 2;
  localparam int HT = 12;
  localparam int VT = 9;
  localparam int FRAME = HT * VT;  // 108

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] fbuf_rd_addr;
  logic        fbuf_rd_en;
  logic [7:0]  fbuf_rd_data = 8'h00;
  logic [7:0]  pixel_color;
  logic        video_de;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic        ff_mode = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  fbuf_scanout #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SCALING_FACTOR(SF),
    .FBUF_ADDR_WIDTH(16), .FBUF_DATA_WIDTH(8),
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_ACTIVE_HIGH(0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fbuf_rd_addr (fbuf_rd_addr),
    .fbuf_rd_en   (fbuf_rd_en),
    .fbuf_rd_data (fbuf_rd_data),
    .pixel_color  (pixel_color),
    .video_de     (video_de),
    .hsync        (hsync),
    .vsync        (vsync),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous-read framebuffer: mem[k] = k.
  always @(posedge clk) begin
    if (ff_mode)         fbuf_rd_data <= 8'hFF;
    else if (fbuf_rd_en) fbuf_rd_data <= fbuf_rd_addr[7:0];
    else                 fbuf_rd_data <= 8'hA5;
  end

  // Raster reference, indexed by output sample n (n=0 is the first active pixel of a frame).
  function automatic int hpos(input int n); return n % HT; endfunction
  function automatic int vpos(input int n); return (n / HT) % VT; endfunction
  function automatic logic exp_de(input int n);
    return (hpos(n) < 8) && (vpos(n) < 6);
  endfunction
  function automatic int exp_addr(input int n);
    return (vpos(n) / SF) * FW + hpos(n) / SF;
  endfunction
  function automatic int exp_color(input int n);
    return exp_de(n) ? exp_addr(n) : 0;
  endfunction
  function automatic logic exp_hs(input int n);
    return !((hpos(n) >= 9) && (hpos(n) < 11));
  endfunction
  function automatic logic exp_vs(input int n);
    return !(vpos(n) == 7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"},  32'(fbuf_rd_addr), 32'd0);
    chk({tag, "_en"},    32'(fbuf_rd_en),   32'd0);
    chk({tag, "_pix"},   32'(pixel_color),  32'd0);
    chk({tag, "_de"},    32'(video_de),     32'd0);
    chk({tag, "_fs"},    32'(frame_start),  32'd0);
    chk({tag, "_hs"},    32'(hsync),        32'd1);
    chk({tag, "_vs"},    32'(vsync),        32'd1);
  endtask

  int line0 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int line2 [8] = '{4, 4, 5, 5, 6, 6, 7, 7};
  int pix   [FRAME];
  int de_cnt, hs_low, vs_low, fs_cnt, max_addr;

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");

    // Release; first post-reset edge registers address 0, outputs still idle
    rst_n = 1'b1;
    @(negedge clk);
    chk("s1_en",   32'(fbuf_rd_en),   32'd1);
    chk("s1_addr", 32'(fbuf_rd_addr), 32'd0);
    chk("s1_de",   32'(video_de),     32'd0);
    chk("s1_fs",   32'(frame_start),  32'd0);
    @(negedge clk);

    // Full frame 0, every output on every clock
    de_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; max_addr = 0;
    for (int n = 0; n < FRAME; n++) begin
      chk("f_de",  32'(video_de),    32'(exp_de(n)));
      chk("f_pix", 32'(pixel_color), 32'(exp_color(n)));
      chk("f_hs",  32'(hsync),       32'(exp_hs(n)));
      chk("f_vs",  32'(vsync),       32'(exp_vs(n)));
      chk("f_fs",  32'(frame_start), 32'((n % FRAME) == 0));
      chk("f_en",  32'(fbuf_rd_en),  32'(exp_de(n + 1)));
      if (exp_de(n + 1)) chk("f_addr", 32'(fbuf_rd_addr), 32'(exp_addr(n + 1)));
      pix[n] = int'(pixel_color);
      if (video_de)    de_cnt++;
      if (!hsync)      hs_low++;
      if (!vsync)      vs_low++;
      if (frame_start) fs_cnt++;
      if (fbuf_rd_en && int'(fbuf_rd_addr) > max_addr) max_addr = int'(fbuf_rd_addr);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      chk("l0_pix", 32'(pix[i]),          32'(line0[i]));
      chk("l1_pix", 32'(pix[HT + i]),     32'(line0[i]));
      chk("l2_pix", 32'(pix[2 * HT + i]), 32'(line2[i]));
    end
    chk("de_per_frame", 32'(de_cnt),   32'd48);
    chk("hs_low_clks",  32'(hs_low),   32'd18);
    chk("vs_low_clks",  32'(vs_low),   32'd12);
    chk("fs_pulses",    32'(fs_cnt),   32'd1);
    chk("max_addr",     32'(max_addr), 32'd11);

    // Frame 1 begins exactly 108 clocks later
    chk("f1_fs",  32'(frame_start), 32'd1);
    chk("f1_de",  32'(video_de),    32'd1);
    chk("f1_pix", 32'(pixel_color), 32'd0);

    // Move mid-line into frame 1 (line 1, h=3) and reset asynchronously
    repeat (15) @(negedge clk);
    chk("mid_de",  32'(video_de),    32'd1);
    chk("mid_pix", 32'(pixel_color), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("arst");
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("arst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk("r1_en",   32'(fbuf_rd_en),   32'd1);
    chk("r1_addr", 32'(fbuf_rd_addr), 32'd0);
    chk("r1_de",   32'(video_de),     32'd0);
    @(negedge clk);
    chk("r2_fs", 32'(frame_start), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("r_de",  32'(video_de),    32'd1);
      chk("r_pix", 32'(pixel_color), 32'(line0[i]));
      @(negedge clk);
    end
    chk("r_de_fall", 32'(video_de), 32'd0);

    // Blanking: framebuffer returns 8'hFF constantly
    ff_mode = 1'b1;
    @(negedge clk);
    for (int n = 0; n < FRAME; n++) begin
      if (!video_de) chk("blank_pix", 32'(pixel_color), 32'd0);
      else           chk("act_pix",   32'(pixel_color), 32'hFF);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
